uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_baud_gen.sv | 37 +++
 rtl/uart_tx.sv | 165 ++++++++++++++++
 tb/tb_uart_tx.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- shared constants for the UART transmitter slice.
//   * FSM state encoding (legacy-compatible 3-bit constants)
//   * default bit period, data width, counter widths
//   * even-parity helper, present only when UART_TX_PARITY_EN is defined
package uart_pkg;

   // Clock cycles per serial bit when the instantiating code does not override it.
   localparam int DEFAULT_BAUDRATE = 24;

   // Payload bits per frame (8N1 or 8E1).
   localparam int DATA_BITS = 8;

   // Baud counter width: covers bit periods up to 8191 cycles.
   localparam int BAUD_CNT_W = 13;

   // Bit counter width: indexes data bits 0..7.
   localparam int BIT_CNT_W = 3;

   // Transmitter FSM encoding. ST_PARITY is only reachable when parity is built in.
   typedef logic [2:0] uart_state_t;

   localparam uart_state_t ST_IDLE   = 3'd0;
   localparam uart_state_t ST_START  = 3'd1;
   localparam uart_state_t ST_DATA   = 3'd2;
   localparam uart_state_t ST_STOP   = 3'd3;
   localparam uart_state_t ST_PARITY = 3'd4;

`ifdef UART_TX_PARITY_EN
   // Even parity: the parity bit makes the total count of ones even.
   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen -- bit-period timer for the UART transmitter.
// Counts clock cycles while the transmitter is running and raises bit_end
// for exactly one cycle at the last cycle of every bit period, so the FSM
// changes bit on the edge that closes the period. The count is held at zero
// while idle and is forced back to zero whenever a new frame starts.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int Baudrate = DEFAULT_BAUDRATE
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic restart,
   output logic bit_end
);

   // Terminal count of one bit period.
   localparam logic [BAUD_CNT_W-1:0] LAST_CNT = BAUD_CNT_W'(Baudrate - 1);

   logic [BAUD_CNT_W-1:0] baud_cnt;

   // Strobe on the final cycle of the current bit period.
   assign bit_end = run && (baud_cnt == LAST_CNT);

   // Cycle counter: clears on frame start, at every bit boundary and while idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_cnt <= '0;
      end else if (restart || !run || bit_end) begin
         baud_cnt <= '0;
      end else begin
         baud_cnt <= baud_cnt + BAUD_CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx.sv
// uart_tx -- 8-bit UART transmitter with a one-entry holding buffer.
// Frame: start bit (0), data bits LSB first, optional even parity bit, stop
// bit (1). Each bit lasts Baudrate clock cycles. Build option:
//   UART_TX_PARITY_EN  defined   -> 11-bit 8E1 frame (PARITY state after DATA)
//                      undefined -> 10-bit 8N1 frame, no parity logic
//
// Handshake: a byte is taken from Data_in on any rising Clk edge where Valid
// and Ready are both 1. Ready is the registered inverse of "holding buffer
// full"; Valid seen while Ready is 0 has no effect, and upstream must keep
// Data_in stable until the accepting edge.
//
// The FSM state is exported on state_dbg (uart_pkg ST_* encoding).
module uart_tx
   import uart_pkg::*;
#(
   parameter int Baudrate = DEFAULT_BAUDRATE
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [DATA_BITS-1:0] Data_in,
   input  logic                 Valid,
   output logic                 Ready,
   output logic                 TX,
   output logic                 Busy,
   output logic [2:0]           state_dbg
);

   // Index of the last data bit in the bit counter.
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

   uart_state_t           state;
   logic [DATA_BITS-1:0]  buf_data;
   logic                  buf_full;
   logic [DATA_BITS-1:0]  shift_reg;
   logic [BIT_CNT_W-1:0]  bit_cnt;
   logic                  tx_q;
   logic                  bit_end;
   logic                  load;
   logic                  run;
`ifdef UART_TX_PARITY_EN
   logic                  parity_q;
`endif

   // A frame starts either from IDLE or straight out of a finishing STOP bit,
   // whenever the holding buffer has a byte waiting.
   assign load = buf_full &&
                 ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));

   assign run       = (state != ST_IDLE);
   assign Ready     = ~buf_full;
   assign TX        = tx_q;
   assign Busy      = run;
   assign state_dbg = state;

   uart_baud_gen #(
      .Baudrate (Baudrate)
   ) u_baud_gen (
      .clk     (Clk),
      .rst     (Rst),
      .run     (run),
      .restart (load),
      .bit_end (bit_end)
   );

   // Holding buffer: filled on handshake, emptied when the shifter takes it.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         buf_full <= 1'b0;
         buf_data <= '0;
      end else if (load) begin
         buf_full <= 1'b0;
      end else if (Valid && !buf_full) begin
         buf_full <= 1'b1;
         buf_data <= Data_in;
      end
   end

   // Frame sequencer: drives TX one bit period at a time from the shifter.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state     <= ST_IDLE;
         tx_q      <= 1'b1;
         shift_reg <= '0;
         bit_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               tx_q <= 1'b1;
               if (load) begin
                  state     <= ST_START;
                  tx_q      <= 1'b0;
                  shift_reg <= buf_data;
                  bit_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
                  parity_q  <= even_parity(buf_data);
`endif
               end
            end

            ST_START: begin
               if (bit_end) begin
                  state   <= ST_DATA;
                  tx_q    <= shift_reg[0];
                  bit_cnt <= '0;
               end
            end

            ST_DATA: begin
               if (bit_end) begin
                  if (bit_cnt == LAST_BIT) begin
                     bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                     state   <= ST_PARITY;
                     tx_q    <= parity_q;
`else
                     state   <= ST_STOP;
                     tx_q    <= 1'b1;
`endif
                  end else begin
                     bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
                     shift_reg <= {1'b0, shift_reg[DATA_BITS-1:1]};
                     tx_q      <= shift_reg[1];
                  end
               end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (bit_end) begin
                  state <= ST_STOP;
                  tx_q  <= 1'b1;
               end
            end
`endif

            ST_STOP: begin
               if (bit_end) begin
                  if (load) begin
                     // Back-to-back frame: no idle cycle between stop and start.
                     state     <= ST_START;
                     tx_q      <= 1'b0;
                     shift_reg <= buf_data;
                     bit_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
                     parity_q  <= even_parity(buf_data);
`endif
                  end else begin
                     state <= ST_IDLE;
                     tx_q  <= 1'b1;
                  end
               end
            end

            default: begin
               state <= ST_IDLE;
               tx_q  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- self-checking bench for uart_tx (Baudrate = 24).
// A frame-level model predicts TX/Busy/Ready every cycle from the accepted
// bytes and elapsed time; a behavioural receiver decodes TX into bytes and
// checks them against an expected queue. Honours UART_TX_PARITY_EN.
module tb_uart_tx;

   localparam int B = 24;
`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic       Clk     = 1'b0;
   logic       Rst     = 1'b1;
   logic [7:0] Data_in = 8'h00;
   logic       Valid   = 1'b0;
   logic       Ready;
   logic       TX;
   logic       Busy;
   logic [2:0] state_dbg;

   always #5 Clk = ~Clk;

   uart_tx #(.Baudrate(B)) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .Data_in   (Data_in),
      .Valid     (Valid),
      .Ready     (Ready),
      .TX        (TX),
      .Busy      (Busy),
      .state_dbg (state_dbg)
   );

   // ---------------- bookkeeping ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic cmp_en = 1'b0;
   logic rx_en  = 1'b0;

   logic [7:0] exp_q[$];
   logic [7:0] rx_log[$];
   logic       rx_par_log[$];
   int         busy_runs[$];
   int         busy_run = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level model ----------------
   function automatic logic frame_bit(input logic [7:0] d, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
      if (idx == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   int         cyc       = 0;
   logic       m_full    = 1'b0;
   logic [7:0] m_buf     = 8'h00;
   logic       m_act     = 1'b0;
   int         m_start   = 0;
   logic [7:0] m_byte    = 8'h00;
   int         m_acc_cnt = 0;
   logic       e_tx      = 1'b1;
   logic       e_busy    = 1'b0;
   logic       e_ready   = 1'b1;

   initial begin
      logic acc, done;
      forever begin
         @(posedge Clk or posedge Rst);
         if (Rst) begin
            m_full  = 1'b0;
            m_act   = 1'b0;
            exp_q.delete();
            e_tx    = 1'b1;
            e_busy  = 1'b0;
            e_ready = 1'b1;
         end else begin
            cyc++;
            acc  = Valid && !m_full;
            done = m_act && ((cyc - m_start) == FB * B);
            if ((!m_act || done) && m_full) begin
               m_act   = 1'b1;
               m_start = cyc;
               m_byte  = m_buf;
               m_full  = 1'b0;
            end else if (done) begin
               m_act = 1'b0;
            end
            if (acc) begin
               m_buf  = Data_in;
               m_full = 1'b1;
               m_acc_cnt++;
               exp_q.push_back(Data_in);
            end
            e_ready = !m_full;
            e_busy  = m_act;
            e_tx    = m_act ? frame_bit(m_byte, (cyc - m_start) / B) : 1'b1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge Clk);
         if (cmp_en) begin
            chk("cyc_tx", TX, e_tx);
            chk("cyc_busy", Busy, e_busy);
            chk("cyc_ready", Ready, e_ready);
         end
      end
   end

   // ---------------- Busy run-length monitor ----------------
   initial begin
      forever begin
         @(negedge Clk);
         if (Busy === 1'b1) begin
            busy_run++;
         end else begin
            if (busy_run > 0) busy_runs.push_back(busy_run);
            busy_run = 0;
         end
      end
   end

   // ---------------- behavioural receiver / scoreboard ----------------
   task automatic receive();
      logic [FB-1:0] bits;
      logic [7:0]    data;
      bits = '0;
      for (int p = 0; p <= (FB - 1) * B + B / 2; p++) begin
         if (p > 0) @(negedge Clk);
         if (Rst) return;
         if ((p % B) == B / 2) bits[p / B] = TX;
      end
      data = bits[8:1];
      chk("rx_start_bit", bits[0], 1'b0);
      chk("rx_frame_err", bits[FB-1], 1'b1);
`ifdef UART_TX_PARITY_EN
      chk("rx_parity", bits[9], ^data);
      rx_par_log.push_back(bits[9]);
`endif
      chk("rx_exp_q_nonempty", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) chk("rx_data", data, exp_q.pop_front());
      rx_log.push_back(data);
   endtask

   initial begin
      forever begin
         @(negedge Clk);
         if (rx_en && !Rst && TX === 1'b0) receive();
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_neg(input int n);
      repeat (n) @(negedge Clk);
   endtask

   // Returns at the negedge following the accepting edge; Valid left high.
   task automatic send(input logic [7:0] b);
      int old, n;
      @(negedge Clk);
      Valid   = 1'b1;
      Data_in = b;
      old     = m_acc_cnt;
      n       = 0;
      while (m_acc_cnt == old && n < 5000) begin
         @(negedge Clk);
         n++;
      end
      chk("send_accept", m_acc_cnt != old, 1'b1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((m_act || m_full) && n < 30000) begin
         @(negedge Clk);
         n++;
      end
      chk("idle_reached", n < 30000, 1'b1);
      wait_neg(3);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [FB-1:0] pat55;
      int n0, old, got, n, gap;
`ifdef UART_TX_PARITY_EN
      pat55 = 11'b100_1010_1010;
`else
      pat55 = 10'b10_1010_1010;
`endif

      // Reset state
      wait_neg(3);
      chk("rst_tx", TX, 1'b1);
      chk("rst_busy", Busy, 1'b0);
      chk("rst_ready", Ready, 1'b1);
      Rst    = 1'b0;
      cmp_en = 1'b1;
      rx_en  = 1'b1;
      wait_neg(2);

      // 0x55 from idle: latency, bit pattern, Busy length
      busy_runs.delete();
      n0 = rx_log.size();
      send(8'h55);
      Valid = 1'b0;
      chk("t1_tx_idle_at_accept", TX, 1'b1);
      chk("t1_ready_low", Ready, 1'b0);
      wait_neg(1);
      chk("t1_start_latency", TX, 1'b0);
      for (int k = 0; k < FB; k++) begin
         wait_neg((k == 0) ? B / 2 : B);
         chk("t1_bit", TX, pat55[k]);
      end
      wait_idle();
      chk("t1_busy_runs", busy_runs.size(), 1);
      if (busy_runs.size() > 0) chk("t1_busy_len", busy_runs[0], FB * B);
      chk("t1_rx_count", rx_log.size(), n0 + 1);
      if (rx_log.size() > n0) chk("t1_rx_byte", rx_log[n0], 8'h55);

      // 0xA3 with 0xFF queued behind it
      busy_runs.delete();
      n0 = rx_log.size();
      send(8'hA3);
      chk("t2_ready_low_after_accept", Ready, 1'b0);
      send(8'hFF);
      chk("t2_ready_low_ff_held", Ready, 1'b0);
      wait_neg(5 * B);
      chk("t2_ready_still_low", Ready, 1'b0);
      Valid = 1'b0;
      wait_idle();
      chk("t2_busy_runs", busy_runs.size(), 1);
      if (busy_runs.size() > 0) chk("t2_busy_len_back2back", busy_runs[0], 2 * FB * B);
      chk("t2_rx_count", rx_log.size(), n0 + 2);
      if (rx_log.size() > n0 + 1) begin
         chk("t2_rx_a3", rx_log[n0], 8'hA3);
         chk("t2_rx_ff", rx_log[n0+1], 8'hFF);
      end
`ifdef UART_TX_PARITY_EN
      if (rx_par_log.size() > n0) chk("t2_parity_a3", rx_par_log[n0], 1'b0);
      n0 = rx_log.size();
      send(8'h07);
      Valid = 1'b0;
      wait_idle();
      if (rx_par_log.size() > n0) chk("t2_parity_07", rx_par_log[n0], 1'b1);
`endif

      // Reset during bit 4 of 0x55, then 0x0F
      n0 = rx_log.size();
      send(8'h55);
      Valid = 1'b0;
      wait_neg(1 + 4 * B + 5);
      #3;
      Rst = 1'b1;
      #1;
      chk("t3_async_tx", TX, 1'b1);
      chk("t3_async_busy", Busy, 1'b0);
      chk("t3_async_ready", Ready, 1'b1);
      wait_neg(2);
      Rst = 1'b0;
      wait_neg(3 * B);
      chk("t3_no_frame_bits", rx_log.size(), n0);
      chk("t3_tx_idle", TX, 1'b1);
      send(8'h0F);
      Valid = 1'b0;
      wait_idle();
      chk("t3_rx_count", rx_log.size(), n0 + 1);
      if (rx_log.size() > n0) chk("t3_rx_0f", rx_log[n0], 8'h0F);

      // Continuous Valid, incrementing data
      busy_runs.delete();
      n0 = rx_log.size();
      @(negedge Clk);
      Data_in = 8'h00;
      Valid   = 1'b1;
      old     = m_acc_cnt;
      got     = 0;
      n       = 0;
      while (got < 8 && n < 20000) begin
         @(negedge Clk);
         n++;
         if (m_acc_cnt != old) begin
            old     = m_acc_cnt;
            got++;
            Data_in = Data_in + 8'h01;
         end
      end
      Valid = 1'b0;
      chk("t4_accepts", got, 8);
      wait_idle();
      chk("t4_rx_count", rx_log.size(), n0 + 8);
      for (int i = 0; i < 8; i++) begin
         if (rx_log.size() > n0 + i) chk("t4_rx_seq", rx_log[n0+i], i);
      end
      chk("t4_busy_runs", busy_runs.size(), 1);
      if (busy_runs.size() > 0) chk("t4_busy_len_no_gaps", busy_runs[0], 8 * FB * B);

      // Randomized traffic
      for (int i = 0; i < 25; i++) begin
         gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 400);
         send(8'($urandom_range(0, 255)));
         Valid = 1'b0;
         wait_neg(gap);
      end
      wait_idle();
      chk("final_exp_q_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
